// File: rtl/karplus_strong_poly.sv
// -----------------------------------------------------------------------------
// karplus_strong_poly
//
// Polyphonic Karplus-Strong plucked-string generator. VOICES independent delay
// lines share one synchronous single-port RAM. Each voice owns a region of
// 2^LEN_W words. On every sample_tick the voices are visited in order and their
// filtered outputs are summed. The mixed result is presented on sample.
//
// Ports:
//   clk          system clock
//   aclr_n       asynchronous active-low reset (RAM contents are not cleared)
//   sample_tick  one-cycle request for a new mixed output sample
//   trig_valid   trigger request; accepted when trig_valid & trig_ready
//   trig_ready   high only while idle with no tick waiting or arriving
//   trig_voice   voice to (re)excite or mute
//   trig_len     delay length (0 mutes the voice, 1 is treated as 2)
//   trig_decay   loop damping, 0 = none .. 7 = strongest
//   sample       signed mixed output, held between updates
//   sample_valid one-cycle pulse when sample updates
//   busy         high whenever the sequencer is not idle
//   overrun      sticky: a sample_tick was dropped
//
// Build option:
//   KS_SATURATE_EN  defined   -> sample is the full-scale sum, saturated
//                   undefined -> sample is the sum divided by VOICES (no clipping)
// -----------------------------------------------------------------------------
module karplus_strong_poly #(
    parameter int          VOICES    = 4,
    parameter int          LEN_W     = 8,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                           clk,
    input  logic                                           aclr_n,
    input  logic                                           sample_tick,
    input  logic                                           trig_valid,
    output logic                                           trig_ready,
    input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] trig_voice,
    input  logic [LEN_W-1:0]                               trig_len,
    input  logic [2:0]                                     trig_decay,
    output logic signed [DATA_W-1:0]                       sample,
    output logic                                           sample_valid,
    output logic                                           busy,
    output logic                                           overrun
);
    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int SH    = $clog2(VOICES);
    localparam int ACC_W = DATA_W + SH;
    localparam int AW    = VW + LEN_W;

    typedef enum logic [2:0] {
        S_IDLE, S_EXCITE, S_V_RA, S_V_RB, S_V_CALC, S_V_WR, S_V_SKIP, S_OUT
    } state_t;

    state_t                    state_reg, state_next;
    logic [VW-1:0]             voice_reg, voice_next;
    logic [LEN_W-1:0]          exc_cnt_reg, exc_cnt_next;
    logic [15:0]               lfsr_reg, lfsr_next;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic signed [DATA_W-1:0]  a_reg, a_next;
    logic signed [DATA_W-1:0]  y_reg, y_next;
    logic signed [DATA_W-1:0]  sample_reg, sample_next;
    logic                      sample_valid_reg, sample_valid_next;
    logic                      tick_pending_reg, tick_pending_next;
    logic                      overrun_reg, overrun_next;

    // Sequencer strobes into the per-voice state
    logic                      trig_accept;
    logic                      excite_done;
    logic                      ptr_adv;

    // Per-voice state, flattened so the current voice can be muxed out
    logic [VOICES-1:0]         active_vec;
    logic [VOICES*LEN_W-1:0]   len_flat;
    logic [VOICES*LEN_W-1:0]   ptr_flat;
    logic [VOICES*3-1:0]       decay_flat;
    logic [LEN_W-1:0]          cur_len, cur_ptr, ptr_inc;
    logic [2:0]                cur_decay;
    logic [VW-1:0]             voice_inc;

    // RAM port
    logic [AW-1:0]             ram_addr;
    logic                      ram_we;
    logic signed [DATA_W-1:0]  ram_wdata;
    logic signed [DATA_W-1:0]  ram_rdata;
    logic signed [DATA_W-1:0]  mem [0:(1<<AW)-1];

    // Datapath
    logic signed [DATA_W-1:0]  noise_word, excite_data;
    logic [15:0]               lfsr_step;
    logic signed [DATA_W:0]    pair_sum, avg, damped;
    logic [3:0]                damp_sh;
    logic signed [DATA_W-1:0]  y_calc;
    logic signed [DATA_W-1:0]  mix_out;

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic             active_reg;
            logic [LEN_W-1:0] len_reg;
            logic [LEN_W-1:0] ptr_reg;
            logic [2:0]       decay_reg;
            logic             sel_trig, sel_cur;

            assign sel_trig = trig_accept && (trig_voice == VW'(gi));
            assign sel_cur  = (voice_reg == VW'(gi));

            always_ff @(posedge clk or negedge aclr_n) begin
                if (!aclr_n) begin
                    active_reg <= 1'b0;
                    len_reg    <= '0;
                    ptr_reg    <= '0;
                    decay_reg  <= '0;
                end else begin
                    if (sel_trig) begin
                        if (trig_len == '0) begin
                            active_reg <= 1'b0;
                        end else begin
                            // A one-word loop cannot average two taps, so stretch it
                            len_reg   <= (trig_len == LEN_W'(1)) ? LEN_W'(2) : trig_len;
                            decay_reg <= trig_decay;
                            ptr_reg   <= '0;
                        end
                    end
                    if (excite_done && sel_cur) begin
                        active_reg <= 1'b1;
                    end
                    if (ptr_adv && sel_cur) begin
                        ptr_reg <= ptr_inc;
                    end
                end
            end

            assign active_vec[gi]                  = active_reg;
            assign len_flat[gi*LEN_W +: LEN_W]     = len_reg;
            assign ptr_flat[gi*LEN_W +: LEN_W]     = ptr_reg;
            assign decay_flat[gi*3 +: 3]           = decay_reg;
        end
    endgenerate

    assign cur_len   = len_flat[int'(voice_reg)*LEN_W +: LEN_W];
    assign cur_ptr   = ptr_flat[int'(voice_reg)*LEN_W +: LEN_W];
    assign cur_decay = decay_flat[int'(voice_reg)*3 +: 3];
    assign ptr_inc   = (cur_ptr == cur_len - LEN_W'(1)) ? '0 : cur_ptr + LEN_W'(1);
    assign voice_inc = voice_reg + VW'(1);

    // Noise excitation: top DATA_W bits of the LFSR, halved to leave loop headroom
    assign noise_word  = lfsr_reg[15 -: DATA_W];
    assign excite_data = noise_word >>> 1;
    assign lfsr_step   = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    // Two-tap average at one extra bit, then optional damping by avg/2^(8-decay)
    assign pair_sum = {a_reg[DATA_W-1], a_reg} + {ram_rdata[DATA_W-1], ram_rdata};
    assign avg      = pair_sum >>> 1;
    assign damp_sh  = 4'd8 - {1'b0, cur_decay};
    assign damped   = avg - (avg >>> damp_sh);
    assign y_calc   = DATA_W'((cur_decay == 3'd0) ? avg : damped);

`ifdef KS_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W-1)));
    always_comb begin
        mix_out = DATA_W'(acc_reg);
        if (acc_reg > SAT_MAX) begin
            mix_out = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_reg < SAT_MIN) begin
            mix_out = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    // Dividing by the voice count keeps any sum within DATA_W
    assign mix_out = DATA_W'(acc_reg >>> SH);
`endif

    // Single-port RAM with registered read (one-cycle latency)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    assign trig_ready = (state_reg == S_IDLE) && !tick_pending_reg && !sample_tick;

    always_comb begin
        state_next        = state_reg;
        voice_next        = voice_reg;
        exc_cnt_next      = exc_cnt_reg;
        lfsr_next         = lfsr_reg;
        acc_next          = acc_reg;
        a_next            = a_reg;
        y_next            = y_reg;
        sample_next       = sample_reg;
        sample_valid_next = 1'b0;
        tick_pending_next = tick_pending_reg | sample_tick;
        overrun_next      = overrun_reg | (sample_tick & tick_pending_reg);
        trig_accept       = 1'b0;
        excite_done       = 1'b0;
        ptr_adv           = 1'b0;
        ram_addr          = {voice_reg, cur_ptr};
        ram_we            = 1'b0;
        ram_wdata         = y_reg;

        case (state_reg)
            S_IDLE: begin
                tick_pending_next = 1'b0;
                if (sample_tick || tick_pending_reg) begin
                    // Ticks take priority over triggers
                    acc_next   = '0;
                    voice_next = '0;
                    state_next = active_vec[0] ? S_V_RA : S_V_SKIP;
                end else if (trig_valid) begin
                    trig_accept  = 1'b1;
                    voice_next   = trig_voice;
                    exc_cnt_next = '0;
                    if (trig_len != '0) begin
                        state_next = S_EXCITE;
                    end
                end
            end
            S_EXCITE: begin
                ram_addr     = {voice_reg, exc_cnt_reg};
                ram_we       = 1'b1;
                ram_wdata    = excite_data;
                lfsr_next    = lfsr_step;
                exc_cnt_next = exc_cnt_reg + LEN_W'(1);
                if (exc_cnt_reg == cur_len - LEN_W'(1)) begin
                    excite_done = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_V_RA: begin
                state_next = S_V_RB;
            end
            S_V_RB: begin
                ram_addr   = {voice_reg, ptr_inc};
                a_next     = ram_rdata;
                state_next = S_V_CALC;
            end
            S_V_CALC: begin
                y_next     = y_calc;
                state_next = S_V_WR;
            end
            S_V_WR, S_V_SKIP: begin
                if (state_reg == S_V_WR) begin
                    ram_we   = 1'b1;
                    acc_next = acc_reg + ACC_W'(y_reg);
                    ptr_adv  = 1'b1;
                end
                if (voice_reg == VW'(VOICES-1)) begin
                    state_next = S_OUT;
                end else begin
                    voice_next = voice_inc;
                    state_next = active_vec[voice_inc] ? S_V_RA : S_V_SKIP;
                end
            end
            S_OUT: begin
                sample_next       = mix_out;
                sample_valid_next = 1'b1;
                state_next        = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_reg        <= S_IDLE;
            voice_reg        <= '0;
            exc_cnt_reg      <= '0;
            lfsr_reg         <= LFSR_SEED;
            acc_reg          <= '0;
            a_reg            <= '0;
            y_reg            <= '0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            tick_pending_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            voice_reg        <= voice_next;
            exc_cnt_reg      <= exc_cnt_next;
            lfsr_reg         <= lfsr_next;
            acc_reg          <= acc_next;
            a_reg            <= a_next;
            y_reg            <= y_next;
            sample_reg       <= sample_next;
            sample_valid_reg <= sample_valid_next;
            tick_pending_reg <= tick_pending_next;
            overrun_reg      <= overrun_next;
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;
    assign busy         = (state_reg != S_IDLE);
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_karplus_strong_poly.sv
// -----------------------------------------------------------------------------
// tb_karplus_strong_poly
//
// Directed bench for karplus_strong_poly (VOICES=4, LEN_W=8, DATA_W=16, default
// build without saturation). A table of hand-computed samples covers the first
// eight ticks of a freshly plucked voice; short hand-written sequences cover
// length clamping, decay, tick/trigger priority, overrun, muting and reset.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_karplus_strong_poly;
    logic               clk = 1'b0;
    logic               aclr_n;
    logic               sample_tick;
    logic               trig_valid;
    logic               trig_ready;
    logic [1:0]         trig_voice;
    logic [7:0]         trig_len;
    logic [2:0]         trig_decay;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    always #5 clk = ~clk;

    karplus_strong_poly #(
        .VOICES    (4),
        .LEN_W     (8),
        .DATA_W    (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .sample_tick  (sample_tick),
        .trig_valid   (trig_valid),
        .trig_ready   (trig_ready),
        .trig_voice   (trig_voice),
        .trig_len     (trig_len),
        .trig_decay   (trig_decay),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Tick latency is counted in clock cycles from the tick cycle to the
    // cycle in which sample_valid is high.
    task automatic do_tick(output int lat, output logic signed [15:0] s);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 1;
        while (sample_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        s = sample;
    endtask

    // Issues a trigger, waits for acceptance, then counts busy (EXCITE) cycles.
    task automatic do_trig(input int v, input int len, input int dec,
                           output int busy_cycles, output logic ready_after);
        int wait_cnt;
        @(negedge clk);
        trig_valid = 1'b1;
        trig_voice = 2'(v);
        trig_len   = 8'(len);
        trig_decay = 3'(dec);
        #1;
        wait_cnt = 0;
        while (trig_ready !== 1'b1 && wait_cnt < 200) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        @(negedge clk);
        trig_valid  = 1'b0;
        ready_after = trig_ready;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 600) begin
            @(negedge clk);
            busy_cycles++;
        end
    endtask

    typedef struct {
        int exp_lat;
        int exp_sample;
    } tick_vec_t;

    tick_vec_t          tick_tab [8];
    int                 lat, bc, k, sv_k, acc_k, sv_cnt, prev_abs, cur_abs;
    logic               rdy;
    logic signed [15:0] s;

    initial begin
        // Voice 2, len 4, decay 0, buffer D670 F138 389C 1C4E; only voice active
        tick_tab[0] = '{9, -1803};
        tick_tab[1] = '{9,  1338};
        tick_tab[2] = '{9,  2717};
        tick_tab[3] = '{9,     4};
        tick_tab[4] = '{9,  -233};
        tick_tab[5] = '{9,  2027};
        tick_tab[6] = '{9,  1360};
        tick_tab[7] = '{9,  -114};

        aclr_n      = 1'b0;
        sample_tick = 1'b0;
        trig_valid  = 1'b0;
        trig_voice  = '0;
        trig_len    = '0;
        trig_decay  = '0;
        repeat (3) @(negedge clk);
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_trig_ready", trig_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        aclr_n = 1'b1;

        // Empty tick
        do_tick(lat, s);
        check("empty_tick_lat", lat, 6);
        check("empty_tick_sample", s, 0);
        check("empty_tick_overrun", overrun, 0);
        @(negedge clk);
        check("sample_valid_one_cycle", sample_valid, 0);

        // Pluck voice 2 and step through the table
        do_trig(2, 4, 0, bc, rdy);
        check("v2_ready_low_in_excite", rdy, 0);
        check("v2_excite_cycles", bc, 4);
        for (int i = 0; i < 8; i++) begin
            do_tick(lat, s);
            check($sformatf("v2_tick%0d_lat", i), lat, tick_tab[i].exp_lat);
            check($sformatf("v2_tick%0d_sample", i), s, tick_tab[i].exp_sample);
        end

        // Mute voice 2: no RAM traffic, stays idle, contributes nothing
        do_trig(2, 0, 0, bc, rdy);
        check("mute_v2_busy", bc, 0);
        check("mute_v2_ready", rdy, 1);
        do_tick(lat, s);
        check("mute_v2_lat", lat, 6);
        check("mute_v2_sample", s, 0);

        // Voice 1, len 1 (clamped to 2), strongest decay
        do_trig(1, 1, 7, bc, rdy);
        check("v1_clamp_excite_cycles", bc, 2);
        do_tick(lat, s);
        check("v1_first_lat", lat, 9);
        check("v1_first_sample", s, 339);
        prev_abs = (s < 0) ? -int'(s) : int'(s);
        for (int i = 0; i < 30; i++) begin
            do_tick(lat, s);
            cur_abs = (s < 0) ? -int'(s) : int'(s);
            check($sformatf("v1_decay_nonincr_%0d", i), (cur_abs <= prev_abs), 1);
            prev_abs = cur_abs;
        end
        check("v1_decay_zero", s, 0);

        // Tick and trigger in the same cycle: tick first, trigger after OUT
        @(negedge clk);
        sample_tick = 1'b1;
        trig_valid  = 1'b1;
        trig_voice  = 2'd0;
        trig_len    = 8'd3;
        trig_decay  = 3'd0;
        #1;
        check("ready_low_with_tick", trig_ready, 0);
        @(negedge clk);
        sample_tick = 1'b0;
        k = 1; sv_k = 0; acc_k = 0;
        while (acc_k == 0 && k < 200) begin
            #1;
            if (sample_valid === 1'b1 && sv_k == 0) sv_k = k;
            if (trig_ready === 1'b1) begin
                acc_k = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("tick_first_sv_cycle", sv_k, 9);
        check("trig_accept_cycle", acc_k, 9);
        @(negedge clk);
        trig_valid = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 600) begin
            @(negedge clk);
            bc++;
        end
        check("v0_excite_cycles", bc, 3);
        do_tick(lat, s);
        check("two_voice_lat", lat, 12);

        // Two extra ticks during one busy period
        @(negedge clk);
        sample_tick = 1'b1;
        sv_cnt = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) sv_cnt++;
            sample_tick = (i == 2 || i == 4);
        end
        sample_tick = 1'b0;
        check("overrun_sv_count", sv_cnt, 2);
        check("overrun_set", overrun, 1);
        do_tick(lat, s);
        check("after_overrun_lat", lat, 12);
        check("overrun_sticky", overrun, 1);

        // Mute an active voice
        do_trig(0, 0, 0, bc, rdy);
        check("mute_v0_busy", bc, 0);
        check("mute_v0_ready", rdy, 1);
        do_tick(lat, s);
        check("mute_v0_lat", lat, 9);

        // Re-pluck voice 2 so the held sample is nonzero before reset
        do_trig(2, 4, 0, bc, rdy);
        check("v2_repluck_cycles", bc, 4);
        do_tick(lat, s);
        check("v2_repluck_lat", lat, 12);
        check("v2_repluck_nonzero", (s != 0), 1);

        // Reset while voice 1 is in V_CALC
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        aclr_n = 1'b0;
        sv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (sample_valid !== 1'b0) sv_cnt++;
            if (i == 1) aclr_n = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_sv", sv_cnt, 0);
        check("rst_mid_sample", sample, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_overrun", overrun, 0);
        check("rst_mid_ready", trig_ready, 1);
        do_tick(lat, s);
        check("rst_mid_voices_off_lat", lat, 6);
        check("rst_mid_voices_off_sample", s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/karplus_strong_poly.md
Name: karplus_strong_poly

Overview:
Polyphonic, parametrised successor to the single-voice plucked-string generator. Holds VOICES independent Karplus-Strong delay lines, time-multiplexed over one synchronous single-port RAM. Each voice has its own length, decay and noise excitation. Sits between the note/trigger controller and the audio DAC/mixer path. One mixed sample is produced per sample_tick.

Parameters:
VOICES, 4, number of voices; power of two, 1..16
LEN_W, 8, delay-length width; each voice region is 2^LEN_W words
DATA_W, 16, sample width, 8..16, signed two's complement
LFSR_SEED, 16'hACE1, reset value of noise LFSR; must be nonzero

Ports:
clk  in  1  system clock
aclr_n  in  1  asynchronous active-low reset
sample_tick  in  1  single-cycle pulse requesting one output sample
trig_valid  in  1  trigger request
trig_ready  out  1  trigger accepted when trig_valid&trig_ready
trig_voice  in  clog2(VOICES) (min 1)  target voice
trig_len  in  LEN_W  delay length; 0 = mute voice
trig_decay  in  3  loop damping, 0 = none, 7 = strongest
sample  out  DATA_W  signed mixed output, held between updates
sample_valid  out  1  one-cycle pulse when sample updates
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: a sample_tick was dropped

Behaviour:
- Reset (aclr_n low, async): state IDLE, all voices inactive, per-voice ptr=0, LFSR=LFSR_SEED, sample=0, sample_valid=0, trig_ready=1, busy=0, overrun=0, tick_pending=0. RAM contents are not reset.
- Reset mid-operation aborts immediately. The interrupted tick never produces sample_valid.
- FSM states: IDLE, EXCITE, V_RA, V_RB, V_CALC, V_WR, V_SKIP, OUT.
- trig_ready=1 only in IDLE with tick_pending=0 and sample_tick=0. Simultaneous tick and trigger: tick wins; trigger waits.
- Trigger accept with trig_len=0: voice set inactive; no RAM traffic; stays IDLE.
- Trigger accept with trig_len>=1: len latched, with 1 clamped to 2. Decay latched, ptr=0, then EXCITE.
- EXCITE: one RAM write per clk to voice region addresses 0..len-1.
  - Data = (lfsr[15 -: DATA_W]) >>> 1, signed.
  - LFSR advances each write: Galois, taps 16'hB400, shift right.
  - Voice becomes active after the last write, then IDLE. Retriggering an active voice simply re-excites it.
- sample_tick while busy: sets tick_pending. A tick while tick_pending is already set sets overrun. Pending tick is serviced on return to IDLE.
- Tick service: acc=0, voices visited in order 0..VOICES-1.
  - Inactive voice: V_SKIP, 1 cycle, adds 0.
  - Active voice, 4 cycles. RAM has 1-cycle read latency.
  - V_RA: address ptr.
  - V_RB: address ptr+1, wrapping to 0 when ptr=len-1; capture a.
  - V_CALC: capture b; avg = (a+b)>>>1 computed at DATA_W+1 bits.
  - y = avg for decay 0; otherwise y = avg - (avg >>> (8-decay)). Arithmetic shift, result truncated to DATA_W.
  - V_WR: write y at ptr; acc += y; ptr = ptr+1, wrapping to 0 at len-1.
- acc width is DATA_W+clog2(VOICES), signed.
- OUT: sample registered from acc (see Optional Feature); sample_valid=1 for this cycle; then IDLE.
- Latency from the tick cycle (in IDLE) to the sample_valid cycle: 1 + 4*A + (VOICES-A) + 1 cycles, where A = number of active voices.

Optional Feature:
KS_SATURATE_EN.
- Defined: sample = acc saturated to DATA_W signed range, i.e. the full-scale sum.
- Undefined: sample = acc >>> clog2(VOICES), with no saturation logic. Cannot overflow.

Test Plan:
- Reset, no voices, single tick -> sample_valid exactly 6 clk later (VOICES=4), sample=0, overrun=0.
- Trigger voice 2, len=4, decay=0 -> trig_ready low, 4 EXCITE writes of successive LFSR words starting from seed 16'hACE1.
  - Then 8 ticks -> each sample_valid 9 clk after its tick.
  - Values match bit-exact reference model; with VOICES=4 and macro off, equal to model y>>>2.
- Trigger voice 1, len=1, decay=7 -> length clamped to 2, exactly 2 EXCITE cycles.
  - Repeated ticks -> |sample| non-increasing and reaches 0 in steady state.
- Tick in the same cycle as trig_valid -> tick serviced first.
  - Trigger accepted the cycle after OUT returns to IDLE.
  - Two ticks during one busy period -> overrun=1 (sticky), only one extra sample_valid.
- Trigger voice 0 with len=0 on an active voice -> voice muted; next sample contribution 0; no RAM writes.
- aclr_n pulsed low during V_CALC -> sample=0, sample_valid never pulses, all voices inactive.
  - With KS_SATURATE_EN, 4 voices at +max data -> sample = 2^(DATA_W-1)-1.
